hazard_ctrl: RTL
================

# hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined RISC-V core that succeeds the single-cycle design. It tracks in-flight register writers across NSTAGES post-decode stages (execute, memory, writeback by default). Each cycle it resolves RAW hazards for the instruction in decode by emitting forwarding selects or a stall. It also turns a taken branch or jump from execute into a flush, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- NSTAGES, 3: tracked stages after decode; stage 1 = execute, stage NSTAGES = writeback.
- RWIDTH, 5: register index width.
- CWIDTH, 32: performance counter width.

Ports (FW = $clog2(NSTAGES+1)):
- clk  in  1  core clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- d_valid_i  in  1  decode holds a real instruction.
- d_rs1_i, d_rs2_i  in  RWIDTH  decode source indices.
- d_rs1_used_i, d_rs2_used_i  in  1  source actually read by the opcode.
- d_rd_i  in  RWIDTH  decode destination.
- d_regwren_i  in  1  decode instruction writes rd.
- d_memren_i  in  1  decode instruction is a load.
- redirect_i  in  1  execute resolved a taken branch or jump this cycle.
- stall_o  out  1  hold PC and decode; inject bubble into stage 1.
- flush_o  out  1  kill fetch and decode contents.
- fwd_rs1_o, fwd_rs2_o  out  FW  0 = register file, k = result of stage k.
- stage_valid_o  out  NSTAGES  valid bit per tracked stage.
- stall_cnt_o, flush_cnt_o  out  CWIDTH  saturating event counters.

## Operation
- Each tracked stage k holds {valid, rd, wr, load}. A stage *writes x* when valid & wr & rd==x & x!=0.
- Advance on every posedge: stage[k+1] <= stage[k]; the oldest entry retires.
- Stage 1 receives a bubble when stall_o, flush_o or !d_valid_i. Otherwise it receives the decode fields.
- flush_o = redirect_i & stage_valid[1]. A redirect with stage 1 invalid is ignored.
- Forwarding (macro defined): fwd_rsN_o = the lowest k in 1..NSTAGES-1 whose stage writes d_rsN_i, provided d_rsN_used_i is set. Otherwise 0. The youngest writer wins.
- Stage NSTAGES needs no forward. The register file is write-first.
- Stall (macro defined): stage 1 is a load that writes a used source. This is a load-use hazard.
- stall_o is forced to 0 when flush_o=1. Flush wins because the decode instruction is being discarded.
- stall_o and the fwd outputs are forced to 0 when d_valid_i=0.
- stall_cnt_o increments on every cycle with stall_o=1, and flush_cnt_o on every cycle with flush_o=1. Both saturate at all-ones and never wrap.

## Timing
- stall_o, flush_o and fwd_* are combinational from the stage registers and the current decode inputs, within the same cycle.
- Stage registers and counters update at posedge clk.
- A load-use stall lasts exactly 1 cycle. The following cycle selects fwd=2.
- Reset values: all stage valids 0, counters 0. This yields stall_o=0, flush_o=0 and fwd_*=0 in the cycle after reset.
- Reset asserted mid-stall or mid-flush clears all state on that edge. No pending stall or flush survives.
- stall_o and redirect_i high together: flush_o=1, stall_o=0, and stage 1 receives a bubble.

## Configuration
- HAZARD_FWD_EN defined: forwarding as above. Only load-use stalls occur.
- HAZARD_FWD_EN undefined: fwd_* are tied to 0. stall_o asserts whenever any stage in 1..NSTAGES-1 writes a used source, regardless of the load bit. A dependent ALU op therefore waits NSTAGES-1 cycles.

## Structure
- Shared package hazard_pkg:
  - hazard_entry_t: packed struct {valid, rd, wr, load}.
  - FWD_RF = 0.
  - Bubble constant HAZARD_BUBBLE, all fields 0.
- One sub-module, hazard_match: combinational. It takes a source index, a used flag and the entry array, and returns hit, load-hit and the youngest-hit index. It is instantiated once per source.

## Test plan
- Reset: hold reset 2 cycles, release -> stage_valid_o=0, stall_o=0, flush_o=0, both counters 0.
- Forwarding (HAZARD_FWD_EN): add x5 enters stage 1, decode add x7,x5,x0 -> fwd_rs1_o=1, fwd_rs2_o=0, stall_o=0.
- Youngest writer wins: add x5 in stages 1 and 2 simultaneously -> fwd_rs1_o=1.
- Load-use: lw x6 in stage 1, decode add x7,x6,x6 -> stall_o=1 for 1 cycle and stage_valid_o[0] next cycle = 0. The cycle after that, fwd_rs1_o=fwd_rs2_o=2. stall_cnt_o=1.
- x0 and unused sources: lw x0 in stage 1 with decode reading x0, or d_rs2_used_i=0 matching rd -> no stall, fwd=0.
- Redirect precedence: load-use condition plus redirect_i=1 -> flush_o=1, stall_o=0, stage 1 bubble next cycle, flush_cnt_o=1. Preload flush_cnt_o to all-ones and repeat -> value unchanged.
- No forwarding (HAZARD_FWD_EN undefined, NSTAGES=3): add x5 then dependent add -> stall_o=1 for exactly 2 cycles, fwd always 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
// Contents:
//   MAX_RWIDTH     - storage width of a tracked register index. Indices up to
//                    this width are supported.
//   hazard_entry_t - per-stage writer record {valid, rd, wr, load}.
//   FWD_RF         - forwarding select meaning "read the register file".
//   HAZARD_BUBBLE  - empty stage record.
//   entry_writes() - true when a stage record writes a given non-zero index.
package hazard_pkg;

  localparam int unsigned MAX_RWIDTH = 8;

  typedef struct packed {
    logic                  valid;
    logic [MAX_RWIDTH-1:0] rd;
    logic                  wr;
    logic                  load;
  } hazard_entry_t;

  localparam int unsigned FWD_RF = 0;

  localparam hazard_entry_t HAZARD_BUBBLE = '0;

  // x0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic entry_writes(hazard_entry_t e, logic [MAX_RWIDTH-1:0] x);
    return e.valid & e.wr & (e.rd == x) & (x != '0);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: combinational dependency search for one decode source.
// Ports:
//   src_i      - source register index, zero-extended to MAX_RWIDTH.
//   used_i     - source is actually read by the decode instruction.
//   entries_i  - stage records for stages 1..NSTAGES-1 (index 0 = stage 1).
//                The writeback stage is not searched because the register
//                file is write-first.
//   hit_o      - some searched stage writes the source.
//   load_hit_o - stage 1 is a load that writes the source.
//   idx_o      - lowest stage number that writes the source, FWD_RF if none.
module hazard_match
  import hazard_pkg::*;
#(
  parameter  int unsigned NSTAGES = 3,
  localparam int unsigned FW      = $clog2(NSTAGES + 1)
) (
  input  logic [MAX_RWIDTH-1:0]       src_i,
  input  logic                        used_i,
  input  hazard_entry_t [NSTAGES-2:0] entries_i,
  output logic                        hit_o,
  output logic                        load_hit_o,
  output logic [FW-1:0]               idx_o
);

  // Scan oldest to youngest so the youngest writer is the last to overwrite.
  always_comb begin
    hit_o      = 1'b0;
    load_hit_o = 1'b0;
    idx_o      = FW'(FWD_RF);
    if (used_i) begin
      for (int k = int'(NSTAGES) - 2; k >= 0; k--) begin
        if (entry_writes(entries_i[k], src_i)) begin
          hit_o = 1'b1;
          idx_o = FW'(k + 1);
        end
      end
      load_hit_o = entries_i[0].load & entry_writes(entries_i[0], src_i);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard, forwarding and flush controller for the pipelined
// RISC-V core. Tracks in-flight writers across NSTAGES post-decode stages
// (stage 1 = execute, stage NSTAGES = writeback).
// Build option: define HAZARD_FWD_EN to enable forwarding; only load-use
// hazards then stall. Without it fwd_* are 0 and any in-flight writer of a
// used source (stages 1..NSTAGES-1) stalls decode.
// Ports:
//   clk, reset                 - core clock, synchronous active-high reset.
//   d_valid_i                  - decode holds a real instruction.
//   d_rs1_i/d_rs2_i            - decode source indices.
//   d_rs1_used_i/d_rs2_used_i  - source is read by the opcode.
//   d_rd_i, d_regwren_i        - decode destination and write enable.
//   d_memren_i                 - decode instruction is a load.
//   redirect_i                 - execute resolved a taken branch/jump.
//   stall_o                    - hold PC/decode, bubble into stage 1.
//   flush_o                    - kill fetch and decode.
//   fwd_rs1_o/fwd_rs2_o        - 0 = register file, k = result of stage k.
//   stage_valid_o              - valid bit per tracked stage (bit 0 = stage 1).
//   stall_cnt_o/flush_cnt_o    - saturating event counters.
// RWIDTH must not exceed hazard_pkg::MAX_RWIDTH; NSTAGES must be at least 2.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int unsigned NSTAGES = 3,
  parameter  int unsigned RWIDTH  = 5,
  parameter  int unsigned CWIDTH  = 32,
  localparam int unsigned FW      = $clog2(NSTAGES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d_valid_i,
  input  logic [RWIDTH-1:0]  d_rs1_i,
  input  logic [RWIDTH-1:0]  d_rs2_i,
  input  logic               d_rs1_used_i,
  input  logic               d_rs2_used_i,
  input  logic [RWIDTH-1:0]  d_rd_i,
  input  logic               d_regwren_i,
  input  logic               d_memren_i,
  input  logic               redirect_i,
  output logic               stall_o,
  output logic               flush_o,
  output logic [FW-1:0]      fwd_rs1_o,
  output logic [FW-1:0]      fwd_rs2_o,
  output logic [NSTAGES-1:0] stage_valid_o,
  output logic [CWIDTH-1:0]  stall_cnt_o,
  output logic [CWIDTH-1:0]  flush_cnt_o
);

  hazard_entry_t [NSTAGES-1:0] stage_q, stage_d;
  logic [CWIDTH-1:0]           stall_cnt_q, stall_cnt_d;
  logic [CWIDTH-1:0]           flush_cnt_q, flush_cnt_d;

  logic [MAX_RWIDTH-1:0] rs1_ext, rs2_ext, rd_ext;
  logic                  rs1_hit, rs1_load_hit, rs2_hit, rs2_load_hit;
  logic [FW-1:0]         rs1_idx, rs2_idx;
  logic                  stall_raw;
  logic                  unused_match;

  assign rs1_ext = MAX_RWIDTH'(d_rs1_i);
  assign rs2_ext = MAX_RWIDTH'(d_rs2_i);
  assign rd_ext  = MAX_RWIDTH'(d_rd_i);

  // Dependency search, one instance per decode source.
  hazard_match #(.NSTAGES(NSTAGES)) u_match_rs1 (
    .src_i      (rs1_ext),
    .used_i     (d_rs1_used_i),
    .entries_i  (stage_q[NSTAGES-2:0]),
    .hit_o      (rs1_hit),
    .load_hit_o (rs1_load_hit),
    .idx_o      (rs1_idx)
  );

  hazard_match #(.NSTAGES(NSTAGES)) u_match_rs2 (
    .src_i      (rs2_ext),
    .used_i     (d_rs2_used_i),
    .entries_i  (stage_q[NSTAGES-2:0]),
    .hit_o      (rs2_hit),
    .load_hit_o (rs2_load_hit),
    .idx_o      (rs2_idx)
  );

  // A redirect only counts when the branch/jump in execute is real.
  assign flush_o = redirect_i & stage_q[0].valid;

`ifdef HAZARD_FWD_EN
  assign stall_raw    = rs1_load_hit | rs2_load_hit;
  assign fwd_rs1_o    = d_valid_i ? rs1_idx : FW'(FWD_RF);
  assign fwd_rs2_o    = d_valid_i ? rs2_idx : FW'(FWD_RF);
  assign unused_match = ^{rs1_hit, rs2_hit, stage_q[NSTAGES-1]};
`else
  assign stall_raw    = rs1_hit | rs2_hit;
  assign fwd_rs1_o    = FW'(FWD_RF);
  assign fwd_rs2_o    = FW'(FWD_RF);
  assign unused_match = ^{rs1_load_hit, rs2_load_hit, rs1_idx, rs2_idx,
                          stage_q[NSTAGES-1]};
`endif

  // Flush wins: the decode instruction is discarded, so there is nothing to hold.
  assign stall_o = d_valid_i & stall_raw & ~flush_o;

  // Stage valid bits.
  always_comb begin
    stage_valid_o = '0;
    for (int k = 0; k < int'(NSTAGES); k++) begin
      stage_valid_o[k] = stage_q[k].valid;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  // Next state: shift the writer pipeline and update saturating counters.
  always_comb begin
    stage_d     = stage_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    for (int k = 1; k < int'(NSTAGES); k++) begin
      stage_d[k] = stage_q[k-1];
    end

    if (stall_o || flush_o || !d_valid_i) begin
      stage_d[0] = HAZARD_BUBBLE;
    end else begin
      stage_d[0] = '{valid: 1'b1, rd: rd_ext, wr: d_regwren_i, load: d_memren_i};
    end

    if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CWIDTH'(1);
    end
    if (flush_o && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CWIDTH'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
